count_readout: RTL

COUNT_READOUT -- requirements
Module: count_readout

---
 rtl/count_readout_pkg.sv | 41 ++++
 rtl/readout_watchdog.sv | 30 +++
 rtl/count_readout.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/count_readout_pkg.sv
// Shared types and constants for the count_readout block: FSM states,
// register map addresses, status bit positions and byte-select helper.
package count_readout_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned WD_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACTIVE  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_READY   = 3'd3,
    ST_CLEAR   = 3'd4
  } state_e;

  localparam logic [ADDR_W-1:0] ADDR_CNT0_LO = 4'd0;
  localparam logic [ADDR_W-1:0] ADDR_CNT0_HI = 4'd1;
  localparam logic [ADDR_W-1:0] ADDR_CNT1_LO = 4'd2;
  localparam logic [ADDR_W-1:0] ADDR_CNT1_HI = 4'd3;
  localparam logic [ADDR_W-1:0] ADDR_CNT2_LO = 4'd4;
  localparam logic [ADDR_W-1:0] ADDR_CNT2_HI = 4'd5;
  localparam logic [ADDR_W-1:0] ADDR_CNT3_LO = 4'd6;
  localparam logic [ADDR_W-1:0] ADDR_CNT3_HI = 4'd7;
  localparam logic [ADDR_W-1:0] ADDR_STATUS  = 4'd8;
  localparam logic [ADDR_W-1:0] ADDR_ZERO    = 4'd9;

  localparam int unsigned STAT_READY   = 7;
  localparam int unsigned STAT_TIMEOUT = 6;
  localparam int unsigned STAT_OVERRUN = 5;
  localparam int unsigned STAT_RUN_LSB = 0;

  // Select the low or high byte of a 16-bit snapshot
  function automatic logic [DATA_W-1:0] cnt_byte(input logic [CNT_W-1:0] cnt,
                                                 input logic hi);
    return hi ? cnt[CNT_W-1:DATA_W] : cnt[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/readout_watchdog.sv
// ACTIVE-state watchdog: counts enabled cycles, zeroed by clr, flags expiry
// when the count reaches LIMIT-1. Instantiated only with COUNT_READOUT_TIMEOUT_EN.
module readout_watchdog
  import count_readout_pkg::*;
#(
  parameter logic [WD_W-1:0] LIMIT = 16'd50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic expired
);

  logic [WD_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en && !expired) begin
      r_count <= r_count + WD_W'(1);
    end
  end

  // Expiry is only meaningful while counting; it drives the owner's transition
  assign expired = en && (r_count == (LIMIT - WD_W'(1)));

endmodule

// File: rtl/count_readout.sv
// Snapshot/readout controller for four channel counters with host handshake.
// Optional ACTIVE watchdog enabled by defining COUNT_READOUT_TIMEOUT_EN.
module count_readout
  import count_readout_pkg::*;
#(
  parameter logic [WD_W-1:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        run,
  input  logic [NUM_CH*CNT_W-1:0]  count_flat,
  input  logic                     ack,
  input  logic                     rd_req,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     clear,
  output logic                     irq
);

  state_e                        r_state;
  state_e                        w_state_nxt;
  logic [NUM_CH-1:0][CNT_W-1:0]  r_snap;
  logic [NUM_CH-1:0]             r_run_prev;
  logic                          r_overrun;
  logic                          r_timeout;
  logic [DATA_W-1:0]             r_rd_data;
  logic                          r_rd_valid;
  logic                          r_clear;
  logic                          r_irq;

  logic                          w_wd_expired;
  logic                          w_timeout_hit;
  logic [NUM_CH-1:0]             w_run_rise;
  logic [NUM_CH-1:0]             w_zero_mask;
  logic [DATA_W-1:0]             w_status;
  logic [DATA_W-1:0]             w_rd_mux;

`ifdef COUNT_READOUT_TIMEOUT_EN
  readout_watchdog #(
    .LIMIT   (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (r_state == ST_ACTIVE),
    .clr     (r_state != ST_ACTIVE),
    .expired (w_wd_expired)
  );
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign w_wd_expired         = 1'b0;
`endif

  assign w_run_rise = run & ~r_run_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A run-low exit always wins over a simultaneous watchdog expiry
  always_comb begin
    w_state_nxt   = r_state;
    w_timeout_hit = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (|run) w_state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (run == '0) begin
          w_state_nxt = ST_CAPTURE;
        end else if (w_wd_expired) begin
          w_state_nxt   = ST_CAPTURE;
          w_timeout_hit = 1'b1;
        end
      end
      ST_CAPTURE: w_state_nxt = ST_READY;
      ST_READY: begin
        if (ack) w_state_nxt = ST_CLEAR;
      end
      ST_CLEAR:   w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_status               = '0;
    w_status[STAT_READY]   = (r_state == ST_READY);
    w_status[STAT_TIMEOUT] = r_timeout;
    w_status[STAT_OVERRUN] = r_overrun;
    w_status[STAT_RUN_LSB +: NUM_CH] = run;
    for (int n = 0; n < NUM_CH; n++) begin
      w_zero_mask[n] = (r_snap[n] == '0);
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (rd_addr)
      ADDR_CNT0_LO: w_rd_mux = cnt_byte(r_snap[0], 1'b0);
      ADDR_CNT0_HI: w_rd_mux = cnt_byte(r_snap[0], 1'b1);
      ADDR_CNT1_LO: w_rd_mux = cnt_byte(r_snap[1], 1'b0);
      ADDR_CNT1_HI: w_rd_mux = cnt_byte(r_snap[1], 1'b1);
      ADDR_CNT2_LO: w_rd_mux = cnt_byte(r_snap[2], 1'b0);
      ADDR_CNT2_HI: w_rd_mux = cnt_byte(r_snap[2], 1'b1);
      ADDR_CNT3_LO: w_rd_mux = cnt_byte(r_snap[3], 1'b0);
      ADDR_CNT3_HI: w_rd_mux = cnt_byte(r_snap[3], 1'b1);
      ADDR_STATUS:  w_rd_mux = w_status;
      ADDR_ZERO:    w_rd_mux = DATA_W'(w_zero_mask);
      default:      w_rd_mux = '0;
    endcase
  end

  // Outputs follow the next state so irq/clear line up with READY/CLEAR
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_snap     <= '0;
      r_run_prev <= '0;
      r_overrun  <= 1'b0;
      r_timeout  <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_clear    <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_run_prev <= run;
      r_clear    <= (w_state_nxt == ST_CLEAR);
      r_irq      <= (w_state_nxt == ST_READY);
      r_rd_valid <= rd_req;
      if (rd_req) begin
        r_rd_data <= w_rd_mux;
      end
      if (r_state == ST_CAPTURE) begin
        r_snap    <= count_flat;
        r_overrun <= 1'b0;
      end else if ((r_state == ST_READY) && (|w_run_rise)) begin
        r_overrun <= 1'b1;
      end
      if ((r_state == ST_ACTIVE) && (w_state_nxt == ST_CAPTURE)) begin
        r_timeout <= w_timeout_hit;
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign clear    = r_clear;
  assign irq      = r_irq;

endmodule
